// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq : dot-product sequencer around an unsigned multiply-accumulate.
//
// A host starts a job of `len` operand pairs. The pairs stream through a
// registered multiplier into an accumulator. The pipeline then drains, and
// the sum is held on a result handshake until the consumer takes it.
//
// Optional feature macro: MAC_SEQ_SAT_EN
//   defined   : the accumulator saturates at all-ones on carry.
//   undefined : the accumulator wraps modulo 2^(2*WIDTH).
//   In both builds `ovf` is set on carry and stays set until the next job.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   start/len  : job request and pair count, sampled only in IDLE
//   abort      : cancels the job in RUN or DRAIN, no result is produced
//   busy       : high in RUN, DRAIN and DONE
//   a, b       : operand pair
//   in_valid   : operand pair valid
//   in_ready   : high only in RUN
//   res        : accumulated sum, stable while res_valid is high
//   res_valid  : result available, high only in DONE
//   res_ready  : result consumer accepts
//   ovf        : sticky overflow for the current job
//   dbg_state  : current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds its data stable while valid is high and ready
// is low. Here in_ready and res_valid are decoded from state only, so
// neither depends combinationally on any input.
// ---------------------------------------------------------------------------
module mac_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CNT_W-1:0]   len,
   input  logic               abort,
   output logic               busy,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [2*WIDTH-1:0] res,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               ovf,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] mult;
   logic               mult_vld;
   logic [2*WIDTH-1:0] accum;
   logic               ovf_q;

   logic               beat;
   logic               job_load;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH:0]   sum_ext;
   logic               carry;
   logic [2*WIDTH-1:0] acc_next;

   // A beat can only occur in RUN. When it coincides with abort, the beat
   // is still consumed, because in_ready is high, but it is not used.
   assign beat     = in_valid && (state_q == RUN);
   assign job_load = start && (state_q == IDLE);

   // Zero-extend both operands so the full 2*WIDTH product is kept.
   assign prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   assign sum_ext  = {1'b0, accum} + {1'b0, mult};
   assign carry    = sum_ext[2*WIDTH];

`ifdef MAC_SEQ_SAT_EN
   // Once the accumulator reaches all-ones, every further nonzero add
   // carries again, so it stays pinned at all-ones for the rest of the job.
   assign acc_next = carry ? {(2*WIDTH){1'b1}} : sum_ext[2*WIDTH-1:0];
`else
   assign acc_next = sum_ext[2*WIDTH-1:0];
`endif

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (beat && (cnt == CNT_W'(1))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = abort ? IDLE : DONE;
         end
         DONE: begin
            // start is not looked at here. A job needs a fresh start in IDLE.
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         mult     <= '0;
         mult_vld <= 1'b0;
         accum    <= '0;
         ovf_q    <= 1'b0;
      end else if (job_load) begin
         cnt      <= len;
         mult     <= '0;
         mult_vld <= 1'b0;
         accum    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         // The pending product is added every cycle it is valid. This
         // overlaps with the next beat's multiply, so back-to-back beats
         // never stall the accumulator.
         if (mult_vld) begin
            accum <= acc_next;
            ovf_q <= ovf_q | carry;
         end
         if (beat && !abort) begin
            mult     <= prod;
            mult_vld <= 1'b1;
            cnt      <= cnt - CNT_W'(1);
         end else begin
            mult_vld <= 1'b0;
         end
      end
   end

   // ---------------- outputs ----------------
   // accum only changes while the job is active, so res is stable in DONE.
   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == RUN);
   assign res_valid = (state_q == DONE);
   assign res       = accum;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: doc/mac_seq.md
# mac_seq

Dot-product sequencer wrapping an unsigned multiply-accumulate datapath: a registered multiply stage followed by an accumulator. A host issues a job of `len` operand pairs. The block streams the pairs through the MAC under a valid/ready handshake, drains the pipeline, and presents the accumulated sum on a held result handshake. It sits between a matrix-operand fetch unit and the result writer, and is the sole owner of the MAC's clear and enable.

## Interface
- `WIDTH`, 8: operand width; product, accumulator and result are 2*WIDTH bits.
- `CNT_W`, 8: width of the job length and beat counter.

- `clk` input 1: the only clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: job request; sampled only in IDLE.
- `len` input CNT_W: number of operand pairs, sampled with `start`.
- `abort` input 1: cancels the job in RUN or DRAIN.
- `busy` output 1: high in RUN, DRAIN and DONE.
- `a`, `b` input WIDTH each: operand pair.
- `in_valid` input 1: the operand pair is valid.
- `in_ready` output 1: high only in RUN.
- `res` output 2*WIDTH: accumulated result; stable while `res_valid` is high.
- `res_valid` output 1: result available; high only in DONE.
- `res_ready` input 1: result consumer accepts.
- `ovf` output 1: sticky overflow for the current job.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Internal registers:
  - `cnt` (CNT_W): beats remaining.
  - `mult` (2W): registered product.
  - `mult_vld`: `mult` holds an unaccumulated product.
  - `accum` (2W): running sum.
- IDLE:
  - `start`=1 with `len`≠0: clear `mult`, `mult_vld`, `accum` and `ovf`; set `cnt` = `len`; go to RUN.
  - `start`=1 with `len`=0: clear `accum` and `ovf`; go directly to DONE, giving `res`=0.
- RUN: on each beat (`in_valid` & `in_ready`):
  - `mult` <= `a`*`b` (unsigned, full 2W product), `mult_vld` <= 1, `cnt` <= `cnt`-1.
  - A cycle with no beat clears `mult_vld`.
  - A beat with `cnt`=1 moves the block to DRAIN.
- Every cycle with `mult_vld`=1: `accum` <= `accum` + `mult`. This holds in RUN and DRAIN, including back-to-back beats.
- DRAIN: `in_ready`=0. The final product is accumulated, `mult_vld` clears, and the block moves to DONE.
- DONE:
  - `res_valid`=1 and `res`=`accum`, both held until `res_ready`=1.
  - When `res_ready`=1, go to IDLE. `accum` retains its value until the next `start`.
- Arithmetic: `accum` wraps modulo 2^(2W). `ovf` is set on any carry out of `accum` and is sticky until the next accepted `start`.
- Boundary rules:
  - `start` is ignored outside IDLE.
  - `start` in the same cycle as the DONE handshake is ignored; `start` must be reasserted in IDLE.
  - `abort` in RUN or DRAIN: go to IDLE next cycle, clear `mult_vld`, produce no result. If `abort` coincides with a beat, abort wins and the beat is dropped; `in_ready` is still 1 that cycle, so the beat is consumed and discarded.
  - `abort` in IDLE or DONE has no effect.
  - `len` is the maximum value (2^CNT_W − 1): the job runs for exactly that many beats.
- Reset, asserted at any time including mid-job:
  - State goes to IDLE.
  - `cnt`, `mult`, `mult_vld`, `accum` and `ovf` go to 0.
  - Outputs: `busy`=0, `in_ready`=0, `res_valid`=0, `res`=0, `ovf`=0.

## Timing
- `start` accepted at edge 0 → RUN from cycle 1; `in_ready`=1 from cycle 1.
- No stalls, N beats in cycles 1..N → DRAIN in cycle N+1 → `res_valid`=1 in cycle N+2.
- Last-beat acceptance to `res_valid`: exactly 2 cycles, regardless of earlier stalls.
- `len`=0: `res_valid`=1 in the cycle after `start`.
- Minimum job-to-job spacing: one IDLE cycle after the result handshake.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.

## Configuration
- `MAC_SEQ_SAT_EN` defined: accumulation saturates. On carry, `accum` is held at all-ones (2^(2W)−1) for the rest of the job, and `ovf` is set.
- `MAC_SEQ_SAT_EN` undefined: `accum` wraps modulo 2^(2W), and `ovf` is still set.

## Test plan
- Reset during RUN after 3 beats → all outputs 0, state IDLE; a new job of `len`=2 with pairs (2,3),(4,5) → `res`=26.
- `len`=4, pairs (1,1),(2,2),(3,3),(4,4), no stalls → `res_valid` in cycle 6 after `start`, `res`=30, `ovf`=0.
- Same job with `in_valid` low for 2 cycles between beats 2 and 3 → `res`=30, `res_valid` 2 cycles after the 4th beat.
- `len`=0 → `res_valid` next cycle with `res`=0. Hold `res_ready`=0 for 5 cycles → `res` stable, `start` ignored.
- W=8, `len`=2, pairs (255,255)×2 → 130050 wraps to 64514 with `ovf`=1; with `MAC_SEQ_SAT_EN` defined → `res`=65535, `ovf`=1.
- `abort` coinciding with the last beat of a `len`=3 job → IDLE next cycle, `res_valid` never asserts; the following job computes its sum from a cleared accumulator.
